// File: rtl/dlatch_nor.sv
`default_nettype none
// ============================================================================
// Module   : dlatch_nor
// Brief    : Clock-synchronous model of a NOR-based gated D latch with
//            complementary outputs.
// Revision : 1.0 - initial release
// ============================================================================
module dlatch_nor #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             En,
    input  logic [WIDTH-1:0] D,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] not_Q
);

    logic [WIDTH-1:0] r_state;
    logic [WIDTH-1:0] w_set;
    logic [WIDTH-1:0] w_reset;
    logic [WIDTH-1:0] w_next;

    // En/D steer the SR core; set and reset are mutually exclusive by
    // construction, so the forbidden S=R=1 input never reaches the state.
    generate
        for (genvar i = 0; i < WIDTH; i++) begin : g_bit
            assign w_set[i]   = En & D[i];
            assign w_reset[i] = En & ~D[i];
            assign w_next[i]  = w_set[i] | (~w_reset[i] & r_state[i]);
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= '0;
        end else begin
            r_state <= w_next;
        end
    end

    assign Q     = r_state;
    assign not_Q = ~r_state;

endmodule
`default_nettype wire

// File: tb/tb_dlatch_nor.sv
`default_nettype none
// ============================================================================
// Module   : tb_dlatch_nor
// Brief    : Table-driven self-checking bench for dlatch_nor (WIDTH=1 and 4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_dlatch_nor;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en  = 1'b0;
    logic       d   = 1'b0;
    logic       q, nq;
    logic [3:0] d4 = 4'h0;
    logic [3:0] q4, nq4;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    dlatch_nor #(.WIDTH(1)) dut (
        .clk(clk), .rst(rst), .En(en), .D(d), .Q(q), .not_Q(nq)
    );

    dlatch_nor #(.WIDTH(4)) dut4 (
        .clk(clk), .rst(rst), .En(en), .D(d4), .Q(q4), .not_Q(nq4)
    );

    typedef struct {
        logic rst;
        logic en;
        logic d;
        logic exp_q;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [3:0] got, input logic [3:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%h expected=%h", name, got, exp);
        end
    endtask

    task automatic add(input logic r, input logic e, input logic dd, input logic eq);
        vec_t v;
        v.rst = r; v.en = e; v.d = dd; v.exp_q = eq;
        vecs.push_back(v);
    endtask

    initial begin
        // reset, then hold with D=1 after release
        add(1, 0, 0, 0);
        add(0, 0, 1, 0);
        add(0, 0, 1, 0);
        // loads
        add(0, 1, 0, 0);
        add(0, 1, 1, 1);
        add(0, 1, 0, 0);
        // hold 0 for five edges while D=1, then load 1
        for (int k = 0; k < 5; k++) add(0, 0, 1, 0);
        add(0, 1, 1, 1);
        // hold 1 while D toggles
        add(0, 0, 0, 1);
        add(0, 0, 1, 1);
        add(0, 0, 0, 1);
        add(0, 1, 1, 1);

        @(negedge clk);
        check("reset_q4", q4, 4'h0);
        check("reset_nq4", nq4, 4'hF);

        foreach (vecs[i]) begin
            rst = vecs[i].rst;
            en  = vecs[i].en;
            d   = vecs[i].d;
            @(negedge clk);
            check($sformatf("vec%0d_q", i), {3'b0, q}, {3'b0, vecs[i].exp_q});
            check($sformatf("vec%0d_nq", i), {3'b0, nq}, {3'b0, ~vecs[i].exp_q});
        end

        // async reset between edges with Q=1, En=1, D=1
        check("pre_rst_q", {3'b0, q}, 4'h1);
        #2 rst = 1'b1;
        #1;
        check("async_rst_q", {3'b0, q}, 4'h0);
        check("async_rst_nq", {3'b0, nq}, 4'h1);
        @(posedge clk);
        #1;
        check("rst_held_q", {3'b0, q}, 4'h0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("rst_release_q", {3'b0, q}, 4'h1);
        check("rst_release_nq", {3'b0, nq}, 4'h0);

        // WIDTH=4 load
        @(negedge clk);
        en = 1'b1;
        d4 = 4'hA;
        @(negedge clk);
        check("w4_q", q4, 4'hA);
        check("w4_nq", nq4, 4'h5);
        en = 1'b0;
        d4 = 4'h3;
        @(negedge clk);
        check("w4_hold_q", q4, 4'hA);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // complement relation observed on every falling edge
    always @(negedge clk) begin
        checks++;
        if ((nq !== ~q) || (nq4 !== ~q4)) begin
            errors++;
            $display("FAIL complement: q=%b nq=%b q4=%h nq4=%h", q, nq, q4, nq4);
        end
    end

endmodule
`default_nettype wire
